// File: rtl/share_capture_unit.sv
// share_capture_unit: waits a settle time after each launch, captures the gadget share vector and checks its XOR recombination
module share_capture_unit #(
    parameter int OUT_SIZE      = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                launch,
    input  logic                exp_bit,
    input  logic [OUT_SIZE-1:0] dut_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [OUT_SIZE-1:0] res_data,
    output logic                res_unmasked,
    output logic                res_match,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    ovr_cnt,
    output logic                busy
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          exp_q;
    logic          xfer, ovr, cap, cap_err;
    assign xfer    = state == HOLD && res_valid && res_ready;
    assign ovr     = launch && (state == SETTLE || (state == HOLD && !xfer));
    assign cap     = state == SETTLE && cnt == '0;
    assign cap_err = cap && ((^dut_out) != exp_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            exp_q        <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_unmasked <= 1'b0;
            res_match    <= 1'b0;
            err_cnt      <= '0;
            ovr_cnt      <= '0;
            busy         <= 1'b0;
        end else begin
            if (ovr && ovr_cnt != '1) ovr_cnt <= ovr_cnt + CNT_W'(1);
            if (cap_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            case (state)
                IDLE: if (launch) begin
                    state <= SETTLE;
                    busy  <= 1'b1;
                    cnt   <= CW'(SETTLE_CYCLES - 1);
                    exp_q <= exp_bit;
                end
                SETTLE: if (!cap) cnt <= cnt - CW'(1);
                else begin
                    state        <= HOLD;
                    res_data     <= dut_out;
                    res_unmasked <= ^dut_out;
                    res_match    <= (^dut_out) == exp_q;
                    res_valid    <= 1'b1;
                end
                HOLD: if (xfer) begin
                    res_valid <= 1'b0;
                    // back-to-back launch on the transfer edge skips IDLE
                    if (launch) begin
                        state <= SETTLE;
                        cnt   <= CW'(SETTLE_CYCLES - 1);
                        exp_q <= exp_bit;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_share_capture_unit.sv
// tb_share_capture_unit: directed scoreboard bench; a: 2 shares, settle 4; b: 1 share, settle 1, 2-bit counters
module tb_share_capture_unit;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic a_launch = 0, a_exp = 0, a_ready = 0;
    logic [1:0] a_out = '0, a_data;
    logic a_valid, a_unm, a_match, a_busy;
    logic [15:0] a_err, a_ovr;

    logic b_launch = 0, b_exp = 0, b_ready = 0;
    logic [0:0] b_out = '0, b_data;
    logic b_valid, b_unm, b_match, b_busy;
    logic [1:0] b_err, b_ovr;

    share_capture_unit #(.OUT_SIZE(2), .SETTLE_CYCLES(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .launch(a_launch), .exp_bit(a_exp), .dut_out(a_out),
        .res_valid(a_valid), .res_ready(a_ready), .res_data(a_data), .res_unmasked(a_unm),
        .res_match(a_match), .err_cnt(a_err), .ovr_cnt(a_ovr), .busy(a_busy));

    share_capture_unit #(.OUT_SIZE(1), .SETTLE_CYCLES(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .launch(b_launch), .exp_bit(b_exp), .dut_out(b_out),
        .res_valid(b_valid), .res_ready(b_ready), .res_data(b_data), .res_unmasked(b_unm),
        .res_match(b_match), .err_cnt(b_err), .ovr_cnt(b_ovr), .busy(b_busy));

    typedef struct packed {logic [1:0] d; logic u; logic m;} exp_t;
    exp_t qa[$], qb[$];
    int n_cmp = 0, n_err = 0;
    int ea = 0, eb = 0, ob = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic e, input logic [1:0] o);
        exp_t x;
        x.d = o; x.u = ^o; x.m = (^o) == e;
        qa.push_back(x);
        if (!x.m && ea < 65535) ea++;
        a_launch = 1; a_exp = e; a_out = o;
    endtask

    task automatic wait_a();
        int lat = 0;
        exp_t x;
        step();
        a_launch = 0; a_ready = 0;
        chk("a_busy_settle", int'(a_busy), 1);
        while (!a_valid && lat < 20) begin step(); lat++; end
        chk("a_latency", lat, 4);
        x = qa.pop_front();
        chk("a_data", int'(a_data), int'(x.d));
        chk("a_unmasked", int'(a_unm), int'(x.u));
        chk("a_match", int'(a_match), int'(x.m));
        chk("a_err_cnt", int'(a_err), ea);
    endtask

    task automatic accept_a();
        a_ready = 1;
        step();
        a_ready = 0;
        chk("a_valid_after_xfer", int'(a_valid), 0);
        chk("a_busy_after_xfer", int'(a_busy), 0);
    endtask

    task automatic push_b(input logic e, input logic o);
        exp_t x;
        x.d = {1'b0, o}; x.u = o; x.m = o == e;
        qb.push_back(x);
        if (!x.m && eb < 3) eb++;
        b_launch = 1; b_exp = e; b_out = o;
    endtask

    task automatic wait_b();
        int lat = 0;
        exp_t x;
        step();
        b_launch = 0;
        while (!b_valid && lat < 20) begin step(); lat++; end
        chk("b_latency", lat, 1);
        x = qb.pop_front();
        chk("b_data", int'(b_data), int'(x.d));
        chk("b_match", int'(b_match), int'(x.m));
        chk("b_err_cnt", int'(b_err), eb);
    endtask

    task automatic accept_b();
        b_ready = 1;
        step();
        b_ready = 0;
        chk("b_valid_after_xfer", int'(b_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(); step();
        rst = 0;
        chk("rst_valid", int'(a_valid), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_data", int'(a_data), 0);
        chk("rst_err", int'(a_err), 0);
        chk("rst_ovr", int'(a_ovr), 0);
        // single matching capture, then a mismatch, then a match
        push_a(1, 2'b01); wait_a(); accept_a();
        push_a(1, 2'b11); wait_a(); accept_a();
        push_a(1, 2'b10); wait_a(); accept_a();
        // long stall in HOLD with an ignored launch
        push_a(0, 2'b00); wait_a();
        for (int i = 0; i < 10; i++) begin
            a_launch = (i == 4);
            a_out = 2'($urandom);
            step();
            chk("stall_valid", int'(a_valid), 1);
            chk("stall_data", int'(a_data), 0);
            chk("stall_match", int'(a_match), 1);
        end
        a_launch = 0;
        chk("stall_ovr", int'(a_ovr), 1);
        accept_a();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_capture_after_ovr", int'(a_valid), 0);
        end
        // transfer and launch on the same edge
        push_a(1, 2'b10); wait_a();
        a_ready = 1;
        push_a(0, 2'b11);
        wait_a();
        chk("b2b_ovr", int'(a_ovr), 1);
        accept_a();
        // reset in the middle of SETTLE
        push_a(0, 2'b01);
        void'(qa.pop_back());
        step();
        a_launch = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        ea = 0;
        chk("midrst_valid", int'(a_valid), 0);
        chk("midrst_busy", int'(a_busy), 0);
        chk("midrst_err", int'(a_err), 0);
        chk("midrst_ovr", int'(a_ovr), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_capture", int'(a_valid), 0);
        end
        // 2-bit counters saturate; settle of one cycle
        chk("b_rst_err", int'(b_err), 0);
        for (int i = 0; i < 5; i++) begin
            push_b(1, 1'b0); wait_b(); accept_b();
        end
        chk("b_err_sat", int'(b_err), 3);
        push_b(1, 1'b1); wait_b();
        for (int i = 0; i < 5; i++) begin
            b_launch = 1;
            step();
            if (ob < 3) ob++;
            chk("b_ovr", int'(b_ovr), ob);
        end
        b_launch = 0;
        chk("b_ovr_sat", int'(b_ovr), 3);
        accept_b();
        chk("b_err_hold", int'(b_err), 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
